// File: rtl/serial_mod5_residue.sv
// Serial MSB-first residue-mod-5 tracker.
// The state register holds the running residue and drives mod directly.
module serial_mod5_residue (
    input  logic       I,
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] mod
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t s_q;
    state_t s_d;

    // next = (2*s + I) mod 5; encodings 5..7 fall back to S0
    always_comb begin
        s_d = S0;
        case (s_q)
            S0:      s_d = I ? S1 : S0;
            S1:      s_d = I ? S3 : S2;
            S2:      s_d = I ? S0 : S4;
            S3:      s_d = I ? S2 : S1;
            S4:      s_d = I ? S4 : S3;
            default: s_d = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q <= S0;
        end else begin
            s_q <= s_d;
        end
    end

    assign mod = s_q;

endmodule

// File: tb/tb_serial_mod5_residue.sv
// Scoreboard bench for serial_mod5_residue.
// Expected residues are queued at drive time and popped after each edge.
module tb_serial_mod5_residue;

    logic       clk;
    logic       reset;
    logic       I;
    logic [2:0] mod;

    int errs;
    int checks;
    int model;
    logic [9:0] covered;
    int exp_q[$];

    serial_mod5_residue dut (
        .I     (I),
        .clk   (clk),
        .reset (reset),
        .mod   (mod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic b, input string tag);
        int e;
        reset = r;
        I     = b;
        if (r) begin
            model = 0;
        end else begin
            covered[model * 2 + int'(b)] = 1'b1;
            model = (2 * model + int'(b)) % 5;
        end
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, int'(mod), e);
    endtask

    task automatic feed(input logic [31:0] bits, input int n, input string tag);
        for (int k = n - 1; k >= 0; k--) begin
            step(1'b0, bits[k], tag);
        end
    endtask

    initial begin
        errs    = 0;
        checks  = 0;
        model   = 0;
        covered = '0;
        reset   = 1'b1;
        I       = 1'b0;
        #2;

        // reset held five edges with I toggling
        for (int k = 0; k < 5; k++) begin
            step(1'b1, k[0], "reset_hold");
        end

        // 42 = 101010
        feed(32'b101010, 6, "v42");
        check("v42_final", int'(mod), 2);

        step(1'b1, 1'b0, "rst");
        feed(32'b1111, 4, "ones15");
        check("ones15_final", int'(mod), 0);
        step(1'b0, 1'b1, "ones31");
        check("ones31_final", int'(mod), 1);

        step(1'b1, 1'b0, "rst");
        feed(32'b00111, 5, "lead0");
        check("lead0_final", int'(mod), 2);

        step(1'b1, 1'b0, "rst");
        feed(32'b111, 3, "mid");
        check("mid_before", int'(mod), 2);

        // reset raised between edges must not act until the next edge
        #2;
        reset = 1'b1;
        I     = 1'b1;
        #2;
        check("sync_reset", int'(mod), 2);
        step(1'b1, 1'b1, "mid_rst");
        check("mid_rst_val", int'(mod), 0);
        feed(32'b10, 2, "mid_after");
        check("mid_after_final", int'(mod), 2);

        // long random stream against the arithmetic model
        step(1'b1, 1'b0, "rst");
        for (int k = 0; k < 200; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), "rand");
        end
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b1, "rand_ones");
        end
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), "rand2");
        end
        check("coverage", int'(covered), 32'h3FF);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
